// File: rtl/vec_lane_sequencer.sv
// Purpose : sequences 256-bit vector ops lane-by-lane through a scalar-lane ALU, chains VDOT reduction.
// Latency : done after T+16 (VADD/SMUL), T+31 (VDOT), T+1 (pass-through); start at edge T.
// Backpressure: none; start is accepted only in IDLE, and a start seen while busy is dropped.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start, opcode       request and operation (0000 VADD, 0001 VDOT, 0010 SMUL, others pass-through)
//   src_a, src_b        operands; SMUL takes its scalar from src_a[15:0]
//   busy, done, result  status, one-cycle completion pulse, destination (held after done)
//   alu_op_1/2/opcode   drive the downstream vector ALU
//   alu_result          combinational ALU result
//   busy_cycles         only with SEQ_PERF_CNT_EN: saturating count of busy edges
//
// Optional feature macro: SEQ_PERF_CNT_EN

module vec_lane_sequencer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              opcode,
  input  logic [LANES*LANE_W-1:0] src_a,
  input  logic [LANES*LANE_W-1:0] src_b,
  output logic                    busy,
  output logic                    done,
  output logic [LANES*LANE_W-1:0] result,
  output logic [LANES*LANE_W-1:0] alu_op_1,
  output logic [LANES*LANE_W-1:0] alu_op_2,
  output logic [3:0]              alu_opcode,
  input  logic [LANES*LANE_W-1:0] alu_result
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]             busy_cycles
`endif
);

  localparam int VW = LANES * LANE_W;
  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;
  localparam logic [3:0] OP_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ELEM,
    S_REDUCE,
    S_PASS,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [3:0]                     opc_q, opc_d;
  logic [VW-1:0]                  a_q, a_d;
  logic [VW-1:0]                  b_q, b_d;
  logic [LW-1:0]                  lane_q, lane_d;
  logic [LANE_W-1:0]              acc_q, acc_d;
  logic [LANES-1:0][LANE_W-1:0]   prod_q, prod_d;
  logic [VW-1:0]                  result_q, result_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  logic [LANE_W-1:0]              alu_lane;

  // Only the low lane of the ALU result is meaningful for lane-wise passes.
  assign alu_lane = alu_result[LANE_W-1:0];

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    a_d      = a_q;
    b_d      = b_q;
    lane_d   = lane_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opc_d  = opcode;
          a_d    = src_a;
          b_d    = src_b;
          lane_d = '0;
          busy_d = 1'b1;
          if (opcode == OP_VADD || opcode == OP_VDOT || opcode == OP_SMUL) begin
            state_d = S_ELEM;
          end else begin
            state_d = S_PASS;
          end
        end
      end

      S_ELEM: begin
        // VDOT parks products in scratch; VADD/SMUL write straight into result.
        if (opc_q == OP_VDOT) begin
          prod_d[lane_q] = alu_lane;
        end else begin
          result_d[int'(lane_q)*LANE_W +: LANE_W] = alu_lane;
        end
        lane_d = lane_q + LW'(1);
        if (lane_q == LAST_LANE) begin
          if (opc_q == OP_VDOT) begin
            // Product 0 seeds the accumulator; the chain starts at product 1.
            state_d = S_REDUCE;
            acc_d   = prod_q[0];
            lane_d  = LW'(1);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            lane_d  = '0;
          end
        end
      end

      S_REDUCE: begin
        acc_d  = alu_lane;
        lane_d = lane_q + LW'(1);
        if (lane_q == LAST_LANE) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          lane_d   = '0;
          result_d = {{(VW-LANE_W){1'b0}}, alu_lane};
        end
      end

      S_PASS: begin
        result_d = alu_result;
        state_d  = S_DONE;
        done_d   = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ALU drive is decoded purely from registered state, so it never glitches on start/src changes.
  always_comb begin
    alu_op_1   = '0;
    alu_op_2   = '0;
    alu_opcode = OP_IDLE;
    case (state_q)
      S_ELEM: begin
        alu_op_1[LANE_W-1:0] = (opc_q == OP_SMUL) ? a_q[LANE_W-1:0]
                                                  : a_q[int'(lane_q)*LANE_W +: LANE_W];
        alu_op_2[LANE_W-1:0] = b_q[int'(lane_q)*LANE_W +: LANE_W];
        alu_opcode           = (opc_q == OP_VADD) ? OP_VADD : OP_SMUL;
      end
      S_REDUCE: begin
        alu_op_1[LANE_W-1:0] = acc_q;
        alu_op_2[LANE_W-1:0] = prod_q[lane_q];
        alu_opcode           = OP_VADD;
      end
      S_PASS: begin
        alu_op_1   = a_q;
        alu_op_2   = b_q;
        alu_opcode = opc_q;
      end
      default: begin
        alu_op_1   = '0;
        alu_op_2   = '0;
        alu_opcode = OP_IDLE;
      end
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] busy_cycles_q, busy_cycles_d;

  always_comb begin
    busy_cycles_d = busy_cycles_q;
    if (busy_q && busy_cycles_q != 16'hFFFF) begin
      busy_cycles_d = busy_cycles_q + 16'd1;
    end
  end

  assign busy_cycles = busy_cycles_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      lane_q   <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_PERF_CNT_EN
      busy_cycles_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SEQ_PERF_CNT_EN
      busy_cycles_q <= busy_cycles_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Purpose : self-checking bench for vec_lane_sequencer with a half-float ALU model behind the alu_* ports.
// Latency : checks completion index against the expected per-opcode latency.
// Backpressure: exercises start-while-busy and mid-operation reset.

module tb_vec_lane_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   opcode;
  logic [255:0] src_a, src_b;
  logic         busy, done;
  logic [255:0] result, alu_op_1, alu_op_2, alu_result;
  logic [3:0]   alu_opcode;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0]  busy_cycles;
`endif

  always #5 clk = ~clk;

  vec_lane_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_op_1   (alu_op_1),
    .alu_op_2   (alu_op_2),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result)
`ifdef SEQ_PERF_CNT_EN
    ,
    .busy_cycles(busy_cycles)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // ---------------- half-precision reference arithmetic ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  ex;
    int  mn;
    real v;
    ex = int'(h[14:10]);
    mn = int'(h[9:0]);
    if (ex == 0)       v = $itor(mn) * pow2(-24);
    else if (ex == 31) v = 65504.0;
    else               v = $itor(mn + 1024) * pow2(ex - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  a;
    int   e;
    int   m;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    if (a == 0.0) return {s, 15'd0};
    if (a >= 65520.0) return {s, 5'h1f, 10'd0};
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    if (a < 1.0) begin
      m = $rtoi(a * 1024.0 + 0.5);
      if (m >= 1024) return {s, 5'd1, 10'd0};
      return {s, 5'd0, 10'(m)};
    end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m >= 1024) begin m = 0; e++; end
    if (e >= 31) return {s, 5'h1f, 10'd0};
    return {s, 5'(e), 10'(m)};
  endfunction

  // ALU model: lane-0 float ops with junk in the upper bits, byte/xor ops for pass-through codes.
  function automatic logic [255:0] alu_fn(input logic [255:0] o1, input logic [255:0] o2, input logic [3:0] opc);
    case (opc)
      4'b0000: return {~o1[255:16], r2h(h2r(o1[15:0]) + h2r(o2[15:0]))};
      4'b0010: return {~o1[255:16], r2h(h2r(o1[15:0]) * h2r(o2[15:0]))};
      4'b0110: return {o1[255:8], o2[7:0]};
      4'b0111: return {o1[255:16], o2[7:0], o1[7:0]};
      default: return o1 ^ {o2[127:0], o2[255:128]} ^ {64{opc}};
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op_1, alu_op_2, alu_opcode);

  // ---------------- sequencer reference model ----------------
  typedef struct {
    logic [3:0]   opc;
    logic [255:0] o1;
    logic [255:0] o2;
  } issue_t;

  issue_t exp_q[$];
  issue_t got_q[$];

  function automatic int model_lat(input logic [3:0] opc);
    if (opc == 4'b0000 || opc == 4'b0010) return 16;
    if (opc == 4'b0001) return 16 + 15;
    return 1;
  endfunction

  // Builds the expected ALU issue list and the final destination value.
  task automatic model_op(input logic [3:0] opc, input logic [255:0] a, input logic [255:0] b,
                          output logic [255:0] res);
    logic [15:0]  prod [16];
    logic [15:0]  acc;
    logic [255:0] o1, o2, r;
    issue_t       it;
    exp_q.delete();
    res = '0;
    if (opc == 4'b0000 || opc == 4'b0010 || opc == 4'b0001) begin
      for (int i = 0; i < 16; i++) begin
        o1 = '0;
        o2 = '0;
        o1[15:0] = (opc == 4'b0010) ? a[15:0] : a[16*i +: 16];
        o2[15:0] = b[16*i +: 16];
        it.opc = (opc == 4'b0000) ? 4'b0000 : 4'b0010;
        it.o1 = o1;
        it.o2 = o2;
        exp_q.push_back(it);
        r = alu_fn(o1, o2, it.opc);
        if (opc == 4'b0001) prod[i] = r[15:0];
        else res[16*i +: 16] = r[15:0];
      end
      if (opc == 4'b0001) begin
        acc = prod[0];
        for (int j = 1; j < 16; j++) begin
          it.opc = 4'b0000;
          it.o1 = {240'd0, acc};
          it.o2 = {240'd0, prod[j]};
          exp_q.push_back(it);
          r = alu_fn(it.o1, it.o2, 4'b0000);
          acc = r[15:0];
        end
        res = {240'd0, acc};
      end
    end else begin
      it.opc = opc;
      it.o1 = a;
      it.o2 = b;
      exp_q.push_back(it);
      res = alu_fn(a, b, opc);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Issues one op and checks latency, result, ALU issue trace and the done pulse.
  // inj_k: cycle index at which a stray start is raised; rst_k: cycle index at which reset hits.
  task automatic run_op(input string tag, input logic [3:0] opc, input logic [255:0] a,
                        input logic [255:0] b, input logic [255:0] exp_res, input int exp_lat,
                        input int inj_k, input int rst_k);
    int     lat;
    int     mism;
    int     extra;
    int     n;
    issue_t it;
    @(negedge clk);
    start  = 1'b1;
    opcode = opc;
    src_a  = a;
    src_b  = b;
    got_q.delete();
    lat = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst busy/done"}, {254'd0, busy, done}, 256'd0);
        check({tag, " rst result"}, result, 256'd0);
        check({tag, " rst alu_opcode"}, {252'd0, alu_opcode}, 256'hF);
        start = 1'b0;
        return;
      end
      if (done) begin
        lat = k;
        break;
      end
      it.opc = alu_opcode;
      it.o1  = alu_op_1;
      it.o2  = alu_op_2;
      got_q.push_back(it);
      if (k == 0) begin
        start  = 1'b0;
        src_a  = rnd256();
        src_b  = rnd256();
        opcode = 4'($urandom);
      end
      if (k == inj_k) begin
        start  = 1'b1;
        opcode = 4'b0110;
      end
      if (k == inj_k + 1) start = 1'b0;
    end
    start = 1'b0;
    check({tag, " latency"}, 256'(lat), 256'(exp_lat));
    check({tag, " result"}, result, exp_res);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    mism = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i].opc !== exp_q[i].opc || got_q[i].o1 !== exp_q[i].o1 || got_q[i].o2 !== exp_q[i].o2)
        mism++;
    end
    check({tag, " issue trace mismatches"}, 256'(mism), 256'd0);
    @(negedge clk);
    check({tag, " idle after done"}, {254'd0, busy, done}, 256'd0);
    check({tag, " result held"}, result, exp_res);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check({tag, " no extra activity"}, 256'(extra), 256'd0);
  endtask

  typedef struct {
    string        name;
    logic [3:0]   opc;
    logic [255:0] a;
    logic [255:0] b;
    int           lat;
    logic [255:0] res;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         tbl[4];
    logic [255:0] mres;
    logic [3:0]   ropc;
    logic [255:0] ra, rb;

    tbl[0] = '{"vadd_ones", 4'b0000, {16{16'h3C00}}, {16{16'h3C00}}, 16, {16{16'h4000}}};
    tbl[1] = '{"smul_two",  4'b0010, {240'd0, 16'h4000}, {16{16'h3C00}}, 16, {16{16'h4000}}};
    tbl[2] = '{"vdot_ones", 4'b0001, {16{16'h3C00}}, {16{16'h3C00}}, 31, {240'd0, 16'h4C00}};
    tbl[3] = '{"sll_pass",  4'b0110, {240'd0, 16'h1234}, {248'd0, 8'hAB}, 1, 256'h12AB};

    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = 4'd0;
    src_a  = '0;
    src_b  = '0;
    repeat (2) @(negedge clk);
    check("reset busy/done", {254'd0, busy, done}, 256'd0);
    check("reset result", result, 256'd0);
    check("reset alu_op_1", alu_op_1, 256'd0);
    check("reset alu_op_2", alu_op_2, 256'd0);
    check("reset alu_opcode", {252'd0, alu_opcode}, 256'hF);
    rst_n = 1'b1;

    // Directed table vectors; expected results are fixed constants, trace from the model.
    for (int i = 0; i < 4; i++) begin
      model_op(tbl[i].opc, tbl[i].a, tbl[i].b, mres);
      run_op(tbl[i].name, tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, -1, -1);
    end

    // Stray start at T+5 of a VADD must be ignored.
    model_op(4'b0000, {16{16'h3C00}}, {16{16'h3C00}}, mres);
    run_op("vadd_stray_start", 4'b0000, {16{16'h3C00}}, {16{16'h3C00}}, {16{16'h4000}}, 16, 4, -1);

    // Reset in the middle of a VDOT, then a clean VADD.
    model_op(4'b0001, {16{16'h3C00}}, {16{16'h3C00}}, mres);
    run_op("vdot_reset", 4'b0001, {16{16'h3C00}}, {16{16'h3C00}}, 256'd0, 31, -1, 8);
    @(negedge clk);
    rst_n = 1'b1;
    model_op(4'b0000, {16{16'h3C00}}, {16{16'h3C00}}, mres);
    run_op("vadd_after_reset", 4'b0000, {16{16'h3C00}}, {16{16'h3C00}}, {16{16'h4000}}, 16, -1, -1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 5))
        0: ropc = 4'b0000;
        1: ropc = 4'b0001;
        2: ropc = 4'b0010;
        default: ropc = 4'($urandom_range(3, 15));
      endcase
      ra = rnd256();
      rb = rnd256();
      model_op(ropc, ra, rb, mres);
      run_op($sformatf("rand%0d_op%0h", i, ropc), ropc, ra, rb, mres, model_lat(ropc), -1, -1);
    end

`ifdef SEQ_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("perf reset", {240'd0, busy_cycles}, 256'd0);
    rst_n = 1'b1;
    model_op(4'b0000, {16{16'h3C00}}, {16{16'h3C00}}, mres);
    run_op("perf_vadd", 4'b0000, {16{16'h3C00}}, {16{16'h3C00}}, {16{16'h4000}}, 16, -1, -1);
    model_op(4'b0001, {16{16'h3C00}}, {16{16'h3C00}}, mres);
    run_op("perf_vdot", 4'b0001, {16{16'h3C00}}, {16{16'h3C00}}, {240'd0, 16'h4C00}, 31, -1, -1);
    check("perf busy_cycles", {240'd0, busy_cycles}, 256'd49);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
